// File: rtl/seq_flow_pkg.sv
// Shared definitions for the seq_flow sequencer: FSM state type and default
// sizing constants.
package seq_flow_pkg;

    localparam int unsigned DEF_WIDTH       = 8;
    localparam int unsigned DEF_A_LIMIT     = 8;
    localparam int unsigned DEF_WAIT_CYCLES = 4;
    localparam int unsigned DEF_C_STEPS     = 2;

    typedef enum logic [2:0] {
        S_INC_A = 3'd0,
        S_WAIT  = 3'd1,
        S_INC_C = 3'd2,
        S_CHK_D = 3'd3,
        S_DONE  = 3'd4
    } seq_state_e;

endpackage : seq_flow_pkg

// File: rtl/seq_delay_timer.sv
// Loadable down-counter with a zero flag; load wins over decrement and the
// count saturates at zero.
module seq_delay_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule : seq_delay_timer

// File: rtl/seq_flow_top.sv
// Self-running micro-program sequencer: count a up to A_LIMIT, idle, bump c,
// conditionally set d, then hold until reset.
module seq_flow_top
    import seq_flow_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned A_LIMIT     = DEF_A_LIMIT,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int unsigned C_STEPS     = DEF_C_STEPS
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d
);

    // One timer serves both the wait delay and the c step count.
    localparam int unsigned T_MAX = (WAIT_CYCLES > C_STEPS) ? WAIT_CYCLES : C_STEPS;
    localparam int unsigned TW    = $clog2(T_MAX + 1);

    seq_state_e state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] a_inc;

    logic          tmr_load;
    logic [TW-1:0] tmr_load_val;
    logic          tmr_dec;
    logic          tmr_zero;

    seq_delay_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    assign a_inc = a_q + WIDTH'(1);

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        c_d          = c_q;
        d_d          = d_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;

        unique case (state_q)
            S_INC_A: begin
                a_d = a_inc;
                if (a_inc == WIDTH'(A_LIMIT)) begin
                    b_d          = WIDTH'(1);
                    tmr_load     = 1'b1;
                    tmr_load_val = TW'(WAIT_CYCLES - 1);
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tmr_zero) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = TW'(C_STEPS - 1);
                    state_d      = S_INC_C;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            S_INC_C: begin
                c_d = c_q + WIDTH'(1);
                if (tmr_zero) begin
                    state_d = S_CHK_D;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            S_CHK_D: begin
                if (a_q != WIDTH'(A_LIMIT)) begin
                    d_d = WIDTH'(1);
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_INC_A;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_INC_A;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
        end
    end

    assign a = a_q;
    assign b = b_q;
    assign c = c_q;
    assign d = d_q;

endmodule : seq_flow_top

// File: tb/tb_seq_flow_top.sv
// Bench for seq_flow_top: a default instance and a swept-parameter instance
// share clock and reset and are checked against a closed-form timeline model.
module tb_seq_flow_top;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] a0, b0, c0, d0;
    logic [7:0] a1, b1, c1, d1;

    int checks = 0;
    int errors = 0;
    int k      = 0;

    always #5 clk = ~clk;

    seq_flow_top u_def (
        .clk (clk),
        .rst (rst),
        .a   (a0),
        .b   (b0),
        .c   (c0),
        .d   (d0)
    );

    seq_flow_top #(
        .WIDTH       (8),
        .A_LIMIT     (3),
        .WAIT_CYCLES (1),
        .C_STEPS     (5)
    ) u_swp (
        .clk (clk),
        .rst (rst),
        .a   (a1),
        .b   (b1),
        .c   (c1),
        .d   (d1)
    );

    // Expected values as a function of edges elapsed since the last reset edge.
    function automatic logic [7:0] m_a(int kk, int lim);
        return 8'((kk < lim) ? kk : lim);
    endfunction

    function automatic logic [7:0] m_b(int kk, int lim);
        return (kk >= lim) ? 8'd1 : 8'd0;
    endfunction

    function automatic logic [7:0] m_c(int kk, int lim, int w, int cs);
        int v;
        v = kk - (lim + w);
        if (v < 0)  v = 0;
        if (v > cs) v = cs;
        return 8'(v);
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got=%0d exp=%0d", name, k, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_def_a"}, a0, m_a(k, 8));
        chk({tag, "_def_b"}, b0, m_b(k, 8));
        chk({tag, "_def_c"}, c0, m_c(k, 8, 4, 2));
        chk({tag, "_def_d"}, d0, 8'd0);
        chk({tag, "_swp_a"}, a1, m_a(k, 3));
        chk({tag, "_swp_b"}, b1, m_b(k, 3));
        chk({tag, "_swp_c"}, c1, m_c(k, 3, 1, 5));
        chk({tag, "_swp_d"}, d1, 8'd0);
    endtask

    task automatic step(input logic r, input string tag);
        rst = r;
        @(posedge clk);
        #1;
        if (!r) k = 0;
        else    k++;
        check_model(tag);
    endtask

    typedef struct {
        logic       rst;
        logic [7:0] a, b, c, d;
    } vec_t;

    vec_t tbl[23];

    initial begin
        tbl[0]  = '{1'b0, 8'd0, 8'd0, 8'd0, 8'd0};
        tbl[1]  = '{1'b0, 8'd0, 8'd0, 8'd0, 8'd0};
        tbl[2]  = '{1'b0, 8'd0, 8'd0, 8'd0, 8'd0};
        tbl[3]  = '{1'b1, 8'd1, 8'd0, 8'd0, 8'd0};
        tbl[4]  = '{1'b1, 8'd2, 8'd0, 8'd0, 8'd0};
        tbl[5]  = '{1'b1, 8'd3, 8'd0, 8'd0, 8'd0};
        tbl[6]  = '{1'b1, 8'd4, 8'd0, 8'd0, 8'd0};
        tbl[7]  = '{1'b1, 8'd5, 8'd0, 8'd0, 8'd0};
        tbl[8]  = '{1'b1, 8'd6, 8'd0, 8'd0, 8'd0};
        tbl[9]  = '{1'b1, 8'd7, 8'd0, 8'd0, 8'd0};
        tbl[10] = '{1'b1, 8'd8, 8'd1, 8'd0, 8'd0};
        tbl[11] = '{1'b1, 8'd8, 8'd1, 8'd0, 8'd0};
        tbl[12] = '{1'b1, 8'd8, 8'd1, 8'd0, 8'd0};
        tbl[13] = '{1'b1, 8'd8, 8'd1, 8'd0, 8'd0};
        tbl[14] = '{1'b1, 8'd8, 8'd1, 8'd0, 8'd0};
        tbl[15] = '{1'b1, 8'd8, 8'd1, 8'd1, 8'd0};
        tbl[16] = '{1'b1, 8'd8, 8'd1, 8'd2, 8'd0};
        tbl[17] = '{1'b1, 8'd8, 8'd1, 8'd2, 8'd0};
        tbl[18] = '{1'b1, 8'd8, 8'd1, 8'd2, 8'd0};
        tbl[19] = '{1'b1, 8'd8, 8'd1, 8'd2, 8'd0};
        tbl[20] = '{1'b1, 8'd8, 8'd1, 8'd2, 8'd0};
        tbl[21] = '{1'b1, 8'd8, 8'd1, 8'd2, 8'd0};
        tbl[22] = '{1'b1, 8'd8, 8'd1, 8'd2, 8'd0};

        // Reset for 3 edges, then the default per-edge trace through edge 20.
        for (int i = 0; i < 23; i++) begin
            step(tbl[i].rst, "trace");
            chk("tbl_a", a0, tbl[i].a);
            chk("tbl_b", b0, tbl[i].b);
            chk("tbl_c", c0, tbl[i].c);
            chk("tbl_d", d0, tbl[i].d);
        end

        for (int i = 0; i < 100; i++) step(1'b1, "hold");
        chk("hold_a", a0, 8'd8);
        chk("hold_c", c0, 8'd2);

        // Mid-sequence reset at edge 5.
        step(1'b0, "pre_mid");
        for (int i = 0; i < 4; i++) step(1'b1, "mid_run");
        step(1'b1, "mid_run");
        chk("mid_a5", a0, 8'd5);
        step(1'b0, "mid_rst");
        chk("mid_rst_a", a0, 8'd0);
        chk("mid_rst_b", b0, 8'd0);
        for (int i = 0; i < 7; i++) step(1'b1, "mid_rel");
        chk("mid_a7", a0, 8'd7);
        step(1'b1, "mid_rel");
        chk("mid_a8", a0, 8'd8);
        chk("mid_b8", b0, 8'd1);

        // Reset asserted at edge 10 (S_WAIT), then full replay.
        step(1'b0, "pre_wait");
        for (int i = 0; i < 9; i++) step(1'b1, "wait_run");
        step(1'b0, "wait_rst");
        chk("wait_rst_b", b0, 8'd0);
        for (int i = 0; i < 20; i++) step(1'b1, "wait_replay");
        chk("wait_replay_c", c0, 8'd2);

        // Reset asserted at edge 30 (S_DONE), then full replay.
        step(1'b0, "pre_done");
        for (int i = 0; i < 29; i++) step(1'b1, "done_run");
        step(1'b0, "done_rst");
        chk("done_rst_c", c0, 8'd0);
        chk("done_rst_c_swp", c1, 8'd0);
        for (int i = 0; i < 20; i++) step(1'b1, "done_replay");

        // Long reset hold keeps everything at zero.
        for (int i = 0; i < 10; i++) step(1'b0, "rst_hold");

        // Random reset pulses against the timeline model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 24) == 0) ? 1'b0 : 1'b1, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seq_flow_top
